// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Holds the sequencer state encoding and the retry counter width.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        RUN       = 2'd2,
        FAULT     = 2'd3
    } seq_state_t;

    localparam int RETRY_W = 4;

    // Counter width for a 0..n-1 count, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level crossing into clk.
// Both flops clear to 0 on the synchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Refclk-domain PLL reset sequencer: pulses the PLL reset, qualifies lock,
// releases the core, and retries on timeout or loss of lock.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1048576,
    parameter int MAX_RETRIES         = 3
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               core_rst,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int CNT_W  = cnt_w(PLL_RST_CYCLES);
    localparam int STAB_W = cnt_w(LOCK_STABLE_CYCLES);
    localparam int TMO_W  = cnt_w(LOCK_TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RTY_LAST  = RETRY_W'(MAX_RETRIES - 1);
    localparam logic [RETRY_W-1:0] RTY_MAX   = RETRY_W'(MAX_RETRIES);

    seq_state_t         state;
    seq_state_t         state_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic [STAB_W-1:0]  stab;
    logic [STAB_W-1:0]  stab_d;
    logic [TMO_W-1:0]   tmo;
    logic [TMO_W-1:0]   tmo_d;
    logic [RETRY_W-1:0] retry_d;
    logic               fail;
    logic               lk_s;
    logic               pll_rst_d;
    logic               core_rst_d;
    logic               ready_d;
    logic               fault_d;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= PLL_RESET;
            cnt         <= '0;
            stab        <= '0;
            tmo         <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            core_rst    <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            stab        <= stab_d;
            tmo         <= tmo_d;
            retry_count <= retry_d;
            pll_rst     <= pll_rst_d;
            core_rst    <= core_rst_d;
            ready       <= ready_d;
            fault       <= fault_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = '0;
        stab_d  = '0;
        tmo_d   = '0;
        retry_d = retry_count;
        fail    = 1'b0;
        unique case (state)
            PLL_RESET: begin
                if (cnt == CNT_LAST) begin
                    state_d = WAIT_LOCK;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                tmo_d  = tmo + 1'b1;
                stab_d = lk_s ? stab + 1'b1 : '0;
                // Stable lock takes priority over a same-cycle timeout.
                if (lk_s && stab == STAB_LAST) begin
                    state_d = RUN;
                    stab_d  = '0;
                    tmo_d   = '0;
                end else if (tmo == TMO_LAST) begin
                    fail = 1'b1;
                end
            end
            RUN: begin
                if (!lk_s) begin
                    fail = 1'b1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = PLL_RESET;
            end
        endcase
        if (fail) begin
            cnt_d  = '0;
            stab_d = '0;
            tmo_d  = '0;
            if (retry_count == RTY_LAST) begin
                retry_d = RTY_MAX;
                state_d = FAULT;
            end else begin
                retry_d = retry_count + 1'b1;
                state_d = PLL_RESET;
            end
        end
    end

    // Decoding the next state into flops keeps outputs aligned with state.
    always_comb begin
        pll_rst_d  = 1'b1;
        core_rst_d = 1'b1;
        ready_d    = 1'b0;
        fault_d    = 1'b0;
        unique case (state_d)
            PLL_RESET: begin
                pll_rst_d = 1'b1;
            end
            WAIT_LOCK: begin
                pll_rst_d = 1'b0;
            end
            RUN: begin
                pll_rst_d  = 1'b0;
                core_rst_d = 1'b0;
                ready_d    = 1'b1;
            end
            FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                pll_rst_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock
// waveforms, all cross-checked against a cycle-level reference model.
module tb_pll_reset_sequencer;

    localparam int PR = 4;
    localparam int ST = 8;
    localparam int TO = 32;
    localparam int MR = 3;

    localparam int P_PULSE = 0;
    localparam int P_WAIT  = 1;
    localparam int P_RUN   = 2;
    localparam int P_FAULT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       core_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;

    int tests = 0;
    int fails = 0;

    int ph;
    int pr_left;
    int age;
    int streak;
    int retries;
    bit s1;
    bit s2;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (PR),
        .LOCK_STABLE_CYCLES  (ST),
        .LOCK_TIMEOUT_CYCLES (TO),
        .MAX_RETRIES         (MR)
    ) dut (
        .refclk      (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .core_rst    (core_rst),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count)
    );

    task automatic model_fail();
        if (retries + 1 == MR) begin
            retries = MR;
            ph      = P_FAULT;
        end else begin
            retries = retries + 1;
            ph      = P_PULSE;
            pr_left = PR;
        end
    endtask

    // Advances the reference by one refclk edge using the sampled inputs.
    task automatic model_edge();
        bit lk;
        if (rst) begin
            ph      = P_PULSE;
            pr_left = PR;
            age     = 0;
            streak  = 0;
            retries = 0;
            s1      = 1'b0;
            s2      = 1'b0;
        end else begin
            lk = s2;
            s2 = s1;
            s1 = pll_locked;
            case (ph)
                P_PULSE: begin
                    pr_left = pr_left - 1;
                    if (pr_left == 0) begin
                        ph     = P_WAIT;
                        age    = 0;
                        streak = 0;
                    end
                end
                P_WAIT: begin
                    age    = age + 1;
                    streak = lk ? streak + 1 : 0;
                    if (streak == ST) ph = P_RUN;
                    else if (age == TO) model_fail();
                end
                P_RUN: begin
                    if (!lk) model_fail();
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [7:0] expect_vec();
        logic [3:0] r;
        r = 4'(retries);
        return {ph == P_PULSE || ph == P_FAULT, ph != P_RUN,
                ph == P_RUN, ph == P_FAULT, r};
    endfunction

    task automatic check(input string tag,
                         input logic [7:0] obs,
                         input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag, {pll_rst, core_rst, ready, fault, retry_count},
              expect_vec());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick("rst");
        rst = 1'b0;
    endtask

    // Returns ticks until pll_rst drops (WAIT_LOCK entry), or -1.
    task automatic wait_pll_low(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick("to_wait");
            if (!pll_rst) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int lvl;
        int seg;
        rst        = 1'b1;
        pll_locked = 1'b0;

        // Reset values
        for (int i = 0; i < 3; i++) tick("reset");
        check("reset_vals", {pll_rst, core_rst, ready, fault, retry_count},
              8'b1100_0000);
        rst = 1'b0;

        // Clean lock
        n = 1;
        for (int i = 0; i < 50; i++) begin
            tick("clean_pulse");
            if (!pll_rst) break;
            n++;
        end
        check_int("clean_pll_rst_len", n, PR);
        for (int i = 0; i < 10; i++) tick("clean_wait");
        pll_locked = 1'b1;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick("clean_lock");
            if (!core_rst) begin
                n = i;
                break;
            end
        end
        check_int("clean_release_lat", n, 2 + ST);
        check_int("clean_ready", int'(ready), 1);
        check_int("clean_retry", int'(retry_count), 0);

        // Loss of lock in RUN
        pll_locked = 1'b0;
        tick("lol_drop");
        pll_locked = 1'b1;
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            tick("lol_wait");
            if (!ready) begin
                n = i;
                break;
            end
        end
        check_int("lol_seen", int'(n > 0), 1);
        check_int("lol_retry", int'(retry_count), 1);
        check_int("lol_core_rst", int'(core_rst), 1);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick("lol_relock");
            if (ready) begin
                n = i;
                break;
            end
        end
        check_int("lol_relocked", int'(n > 0), 1);

        // Glitchy lock
        pll_locked = 1'b0;
        do_reset();
        wait_pll_low(n);
        check_int("glitch_wait_entry", int'(n > 0), 1);
        pll_locked = 1'b1;
        for (int i = 0; i < 5; i++) tick("glitch_hi");
        pll_locked = 1'b0;
        tick("glitch_lo");
        pll_locked = 1'b1;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick("glitch_lock");
            if (!core_rst) begin
                n = i;
                break;
            end
        end
        check_int("glitch_release_lat", n, 2 + ST);
        check_int("glitch_retry", int'(retry_count), 0);

        // Timeout retries into FAULT
        pll_locked = 1'b0;
        do_reset();
        wait_pll_low(n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick("tmo_wait");
            if (pll_rst) begin
                n = i;
                break;
            end
        end
        check_int("tmo_wait_len", n, TO);
        n = 1;
        for (int i = 0; i < 50; i++) begin
            tick("tmo_pulse");
            if (!pll_rst) break;
            n++;
        end
        check_int("tmo_repulse_len", n, PR);
        check_int("tmo_retry1", int'(retry_count), 1);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            tick("tmo_fault");
            if (fault) begin
                n = i;
                break;
            end
        end
        check_int("tmo_fault_seen", int'(n > 0), 1);
        check_int("tmo_fault_pll_rst", int'(pll_rst), 1);
        check_int("tmo_fault_retry", int'(retry_count), MR);
        for (int i = 0; i < 20; i++) tick("fault_hold");
        check_int("fault_sticky", int'(fault), 1);

        // Reset while in FAULT
        do_reset();
        check("rst_in_fault", {pll_rst, core_rst, ready, fault, retry_count},
              8'b1100_0000);

        // Reset mid WAIT_LOCK at tmo=20
        wait_pll_low(n);
        for (int i = 0; i < 20; i++) tick("mid_wait");
        rst = 1'b1;
        tick("mid_rst");
        check("rst_mid_wait", {pll_rst, core_rst, ready, fault, retry_count},
              8'b1100_0000);
        rst = 1'b0;

        // Tie: stable completes on the last timeout cycle
        wait_pll_low(n);
        for (int i = 0; i < TO - ST - 2; i++) tick("tie_wait");
        pll_locked = 1'b1;
        for (int i = 0; i < 12; i++) tick("tie_run");
        check_int("tie_ready", int'(ready), 1);
        check_int("tie_retry", int'(retry_count), 0);

        // One cycle later than the tie: timeout wins
        pll_locked = 1'b0;
        do_reset();
        wait_pll_low(n);
        for (int i = 0; i < TO - ST - 1; i++) tick("late_wait");
        pll_locked = 1'b1;
        for (int i = 0; i < 12; i++) tick("late_run");
        check_int("late_retry", int'(retry_count), 1);

        // Random lock waveforms
        for (int t = 0; t < 6; t++) begin
            pll_locked = 1'b0;
            do_reset();
            seg = 0;
            lvl = 0;
            for (int c = 0; c < 300; c++) begin
                if (seg == 0) begin
                    lvl = ($urandom_range(0, 9) < 7) ? 1 : 0;
                    seg = lvl ? $urandom_range(1, 60)
                              : $urandom_range(1, 12);
                    pll_locked = lvl[0];
                end
                seg--;
                tick("random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
